// File: rtl/uart_byte_fifo_pkg.sv
// uart_byte_fifo_pkg: shared defaults for UART byte buffering (word width, FIFO depth, almost-full threshold)
package uart_byte_fifo_pkg;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AFULL = 12;
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_byte_fifo_mem.sv
// uart_byte_fifo_mem: DEPTH x WIDTH register array, one write port (clk, we, waddr, wdata) and one combinational read port (raddr -> rdata)
module uart_byte_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO with fill level, almost_full and sticky overrun; ports: clk, rst, in_data/in_valid/in_ready, out_data/out_valid/out_ready, count, almost_full, overrun, clr_overrun
module uart_byte_fifo
  import uart_byte_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AFULL = DEF_AFULL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overrun,
  input  logic                   clr_overrun
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nx;
  logic          push, pop;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb
    count_nx = push & ~pop ? count + CW'(1) : pop & ~push ? count - CW'(1) : count;
  // almost_full is registered from next-count so it tracks count cycle for cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nx;
      almost_full <= count_nx >= CW'(AFULL);
      overrun     <= (in_valid & ~in_ready) | (overrun & ~clr_overrun);
    end
  uart_byte_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );
endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb_uart_byte_fifo: scoreboard bench for uart_byte_fifo against a queue-based reference model
module tb_uart_byte_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       almost_full;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] q [$];
  bit ov_m = 1'b0;

  uart_byte_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .almost_full(almost_full), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: at each falling edge compare state against the model, then apply
  // the transfer that the coming rising edge will perform.
  always @(negedge clk or posedge rst)
    if (rst) begin
      q.delete();
      ov_m = 1'b0;
    end else begin
      chk("count", int'(count), q.size());
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
      chk("almost_full", int'(almost_full), int'(q.size() >= AFULL));
      chk("overrun", int'(overrun), int'(ov_m));
      begin
        bit full_now;
        full_now = q.size() == DEPTH;
        if (out_ready && q.size() != 0) begin
          chk("out_data", int'(out_data), int'(q[0]));
          void'(q.pop_front());
        end
        if (in_valid && !full_now) q.push_back(in_data);
        ov_m = (in_valid && full_now) || (ov_m && !clr_overrun);
      end
    end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    // three bytes held, then drained
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    step(2);
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    step(2);
    // fill to full, offer a 17th word, then drain
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    chk("full_count", int'(count), DEPTH);
    chk("full_in_ready", int'(in_ready), 0);
    push_byte(8'hAA);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_count", int'(count), DEPTH);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    out_ready = 1'b1;
    step(DEPTH + 2);
    out_ready = 1'b0;
    // streaming at count 5 through pointer wrap
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'($urandom);
      step();
      chk("stream_count", int'(count), 5);
    end
    in_valid = 1'b0;
    step(6);
    out_ready = 1'b0;
    // full with simultaneous pop and offered push
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    in_valid = 1'b1;
    in_data = 8'hEE;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("popfull_count", int'(count), DEPTH - 1);
    chk("popfull_ready", int'(in_ready), 1);
    chk("popfull_ovr", int'(overrun), 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    out_ready = 1'b1;
    step(DEPTH + 1);
    out_ready = 1'b0;
    // asynchronous reset with seven words queued
    for (int i = 0; i < 7; i++) push_byte(8'($urandom));
    chk("pre_rst_count", int'(count), 7);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ready", int'(in_ready), 1);
    step();
    rst = 1'b0;
    push_byte(8'h55);
    chk("post_rst_data", int'(out_data), 8'h55);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // overflow concurrent with clear: set wins
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    in_valid = 1'b1;
    clr_overrun = 1'b1;
    step();
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    chk("set_wins", int'(overrun), 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      out_ready = ($urandom % 4) != 0 ? (i % 100 < 50) : 1'($urandom);
      clr_overrun = ($urandom % 8) == 0;
      step();
    end
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    out_ready = 1'b1;
    step(DEPTH + 2);
    chk("end_empty", int'(count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
